// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache responder with a single outstanding miss.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read as zero.
module icache_responder #(
  parameter int INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] addr,
  input  logic        rn,
  output logic [31:0] Inst,
  output logic        Read_ready,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 16 - INDEX_W;

  typedef enum logic {IDLE, MISS} state_e;

  state_e               state_q, state_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [31:0]          data_mem [LINES];
  logic [INDEX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic                 inv_seen_q, inv_seen_d;
  logic [31:0]          inst_q, inst_d;
  logic                 rr_q, rr_d;
  logic                 req_q, req_d;
  logic [31:0]          maddr_q, maddr_d;

  logic [INDEX_W-1:0]   req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic                 hit;
  logic                 fill_we;
  logic                 acc_hit, acc_miss;

  assign req_idx = addr[2+INDEX_W-1:2];
  assign req_tag = addr[17:2+INDEX_W];
  assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    miss_idx_d = miss_idx_q;
    miss_tag_d = miss_tag_q;
    inv_seen_d = inv_seen_q;
    inst_d     = inst_q;
    rr_d       = rr_q;
    req_d      = req_q;
    maddr_d    = maddr_q;
    fill_we    = 1'b0;
    acc_hit    = 1'b0;
    acc_miss   = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (inv) begin
            valid_d = '0;
          end else if (rn) begin
            if (hit) begin
              inst_d  = data_mem[req_idx];
              rr_d    = 1'b1;
              acc_hit = 1'b1;
            end else begin
              rr_d       = 1'b0;
              req_d      = 1'b1;
              maddr_d    = {addr[31:2], 2'b00};
              miss_idx_d = req_idx;
              miss_tag_d = req_tag;
              inv_seen_d = 1'b0;
              state_d    = MISS;
              acc_miss   = 1'b1;
            end
          end
        end
        MISS: begin
          if (inv) begin
            valid_d    = '0;
            inv_seen_d = 1'b1;
          end
          if (mem_ready) begin
            fill_we = 1'b1;
            // A fence.i seen at any point during the miss leaves the new line invalid.
            if (!(inv || inv_seen_q)) valid_d[miss_idx_q] = 1'b1;
            inst_d  = mem_data;
            rr_d    = 1'b1;
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      inv_seen_q <= 1'b0;
      inst_q     <= '0;
      rr_q       <= 1'b0;
      req_q      <= 1'b0;
      maddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      miss_idx_q <= miss_idx_d;
      miss_tag_q <= miss_tag_d;
      inv_seen_q <= inv_seen_d;
      inst_q     <= inst_d;
      rr_q       <= rr_d;
      req_q      <= req_d;
      maddr_q    <= maddr_d;
    end
  end

  // Tag and data arrays carry no reset; only the valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[miss_idx_q]  <= miss_tag_q;
      data_mem[miss_idx_q] <= mem_data;
    end
  end

  assign Inst       = inst_q;
  assign Read_ready = rr_q;
  assign mem_req    = req_q;
  assign mem_addr   = maddr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic        unused_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (acc_hit && (hit_q != 32'hFFFF_FFFF))   hit_q  <= hit_q + 32'd1;
      if (acc_miss && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;
  assign unused_bits = ^addr[1:0];
`else
  logic unused_bits;

  assign hit_cnt     = '0;
  assign miss_cnt    = '0;
  assign unused_bits = ^{addr[1:0], acc_hit, acc_miss};
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios then randomized fetch traffic
// checked against a transaction-level cache model (valid/tag/data per line).
module tb_icache_responder;

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, rn, inv, mem_ready;
  logic [31:0] addr, mem_data;
  logic [31:0] Inst, mem_addr, hit_cnt, miss_cnt;
  logic        Read_ready, mem_req;

  icache_responder #(.INDEX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .addr(addr), .rn(rn),
    .Inst(Inst), .Read_ready(Read_ready), .inv(inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cache contents and the externally visible response.
  bit          mv    [16];
  logic [11:0] mtag  [16];
  logic [31:0] mdata [16];
  logic [31:0] exp_inst;
  logic        exp_rr;
  int          m_hits, m_misses;
  bit          h;

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tg, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tg);
    chk({tg, " Read_ready"}, {31'd0, Read_ready}, {31'd0, exp_rr});
    chk({tg, " Inst"}, Inst, exp_inst);
    chk({tg, " hit_cnt"}, hit_cnt, STATS ? m_hits : 0);
    chk({tg, " miss_cnt"}, miss_cnt, STATS ? m_misses : 0);
  endtask

  task automatic clear_valid();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic model_reset();
    clear_valid();
    exp_inst = '0;
    exp_rr   = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_reset();
    rdy = 1'b1; rn = 1'b0; inv = 1'b0; mem_ready = 1'b0;
    addr = '0; mem_data = '0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk_status("reset");
    tick();
    rst = 1'b1;
    tick();
  endtask

  // One complete fetch transaction; on a miss the fill is shaped by gap/stall/inv_mid.
  task automatic fetch(input logic [31:0] a, input logic [31:0] fill, input int gap,
                       input int stall, input bit inv_mid, output bit was_hit);
    int          idx;
    logic [11:0] tg;
    logic [31:0] ma;
    idx = int'(a[5:2]);
    tg  = a[17:6];
    ma  = {a[31:2], 2'b00};
    rdy = 1'b1; rn = 1'b1; addr = a; inv = 1'b0; mem_ready = 1'b0;
    tick();
    rn = 1'b0; addr = $urandom;
    if (mv[idx] && mtag[idx] == tg) begin
      was_hit = 1'b1;
      m_hits++;
      exp_rr   = 1'b1;
      exp_inst = mdata[idx];
      chk("hit mem_req", {31'd0, mem_req}, 32'd0);
      chk_status("hit");
    end else begin
      was_hit = 1'b0;
      m_misses++;
      exp_rr = 1'b0;
      chk("miss mem_req", {31'd0, mem_req}, 32'd1);
      chk("miss mem_addr", mem_addr, ma);
      chk_status("miss");
      for (int i = 0; i < gap; i++) begin
        rn = 1'(($urandom)); addr = $urandom;
        inv = inv_mid && (i == 0);
        tick();
        if (inv) clear_valid();
        rn = 1'b0; inv = 1'b0;
        chk("wait mem_req", {31'd0, mem_req}, 32'd1);
        chk("wait mem_addr", mem_addr, ma);
        chk_status("wait");
      end
      for (int i = 0; i < stall; i++) begin
        rdy = 1'b0; rn = 1'b1; mem_ready = 1'b1; mem_data = $urandom;
        tick();
        chk("stall mem_req", {31'd0, mem_req}, 32'd1);
        chk("stall mem_addr", mem_addr, ma);
        chk_status("stall");
      end
      rdy = 1'b1; rn = 1'b0; mem_ready = 1'b1; mem_data = fill;
      tick();
      mem_ready = 1'b0; mem_data = $urandom;
      if (!inv_mid) begin
        mv[idx] = 1'b1; mtag[idx] = tg; mdata[idx] = fill;
      end
      exp_rr = 1'b1; exp_inst = fill;
      chk("fill mem_req", {31'd0, mem_req}, 32'd0);
      chk_status("fill");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rdy = 1'($urandom);
      rn  = rdy ? 1'b0 : 1'($urandom);
      inv = 1'b0;
      addr = $urandom; mem_ready = 1'($urandom); mem_data = $urandom;
      tick();
      rdy = 1'b1; rn = 1'b0; mem_ready = 1'b0;
      chk("idle mem_req", {31'd0, mem_req}, 32'd0);
      chk_status("idle");
    end
  endtask

  task automatic do_inv();
    rdy = 1'b1; inv = 1'b1; rn = 1'b1; addr = $urandom;
    tick();
    inv = 1'b0; rn = 1'b0;
    clear_valid();
    chk("inv mem_req", {31'd0, mem_req}, 32'd0);
    chk_status("inv");
  endtask

  task automatic reset_mid_miss(input logic [31:0] a);
    do_inv();
    rn = 1'b1; addr = a;
    tick();
    rn = 1'b0;
    chk("rmm mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rmm async mem_req", {31'd0, mem_req}, 32'd0);
    chk("rmm async mem_addr", mem_addr, 32'd0);
    chk_status("rmm async");
    tick();
    rst = 1'b1; mem_ready = 1'b1; mem_data = $urandom;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("rmm after mem_req", {31'd0, mem_req}, 32'd0);
    chk_status("rmm after");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return {r[31:18], 12'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), r[1:0]};
  endfunction

  initial begin
    do_reset();

    // Cold miss, then hits on the same word.
    fetch(32'h0000_0010, 32'h0050_0093, 2, 0, 1'b0, h);
    chk("cold was_hit", {31'd0, h}, 32'd0);
    chk("cold Inst", Inst, 32'h0050_0093);
    fetch(32'h0000_0010, 32'h0, 0, 0, 1'b0, h);
    chk("hit1 was_hit", {31'd0, h}, 32'd1);
    fetch(32'h0000_0010, 32'h0, 0, 0, 1'b0, h);
    chk("hit2 Inst", Inst, 32'h0050_0093);
    chk("stats hit_cnt", hit_cnt, STATS ? 32'd2 : 32'd0);
    chk("stats miss_cnt", miss_cnt, STATS ? 32'd1 : 32'd0);
    idle(3);

    // Conflict on index 4.
    fetch(32'h0000_0050, 32'hDEAD_BEEF, 1, 0, 1'b0, h);
    chk("conflict was_hit", {31'd0, h}, 32'd0);
    fetch(32'h0000_0010, 32'h0050_0093, 0, 0, 1'b0, h);
    chk("refetch was_hit", {31'd0, h}, 32'd0);

    // Invalidate during a miss leaves the filled line invalid.
    fetch(32'h0000_0020, 32'h1234_5678, 2, 0, 1'b1, h);
    chk("invmiss Inst", Inst, 32'h1234_5678);
    fetch(32'h0000_0020, 32'h1234_5678, 0, 0, 1'b0, h);
    chk("invmiss refetch was_hit", {31'd0, h}, 32'd0);

    // rdy low for three cycles with mem_ready pulsing.
    fetch(32'h0000_0030, 32'hCAFE_F00D, 0, 3, 1'b0, h);
    chk("stall Inst", Inst, 32'hCAFE_F00D);

    do_inv();
    fetch(32'h0000_0010, 32'h0050_0093, 0, 0, 1'b0, h);
    chk("post-inv was_hit", {31'd0, h}, 32'd0);
    idle(2);
    reset_mid_miss(32'h0000_0044);

    for (int n = 0; n < 200; n++) begin
      int op, gap;
      op = $urandom_range(0, 19);
      if (op < 15) begin
        gap = $urandom_range(0, 3);
        fetch(rand_addr(), $urandom, gap, $urandom_range(0, 2),
              (gap > 0) && ($urandom_range(0, 7) == 0), h);
      end else if (op < 17) begin
        idle($urandom_range(1, 3));
      end else if (op < 19) begin
        do_inv();
      end else begin
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, giving the log2 of the number of lines (16 one-word lines).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy  input  1  global ready; state frozen while low.
REQ-005 SHALL have port addr  input  32  fetch address; bits [17:2] significant.
REQ-006 SHALL have port rn  input  1  fetch request (read enable).
REQ-007 SHALL have port Inst  output  32  returned instruction word.
REQ-008 SHALL have port Read_ready  output  1  Inst valid for the latest accepted request.
REQ-009 SHALL have port inv  input  1  invalidate all lines (fence.i).
REQ-010 SHALL have port mem_req  output  1  word read request to the memory controller.
REQ-011 SHALL have port mem_addr  output  32  word-aligned miss address.
REQ-012 SHALL have port mem_data  input  32  fill data from the memory controller.
REQ-013 SHALL have port mem_ready  input  1  one-cycle pulse marking mem_data valid.
REQ-014 SHALL have ports hit_cnt  output  32  and miss_cnt  output  32  statistics counters.

Function
REQ-015 SHALL be direct-mapped: index = addr[2+INDEX_W-1:2], tag = addr[17:2+INDEX_W], with one valid bit per line.
REQ-016 SHALL implement states IDLE and MISS; a request is accepted only on a posedge with rdy=1, rn=1 and state IDLE.
REQ-017 SHALL, on an accepted hit, register Inst=line data and Read_ready=1 at that same edge (1-cycle latency) and remain in IDLE.
REQ-018 SHALL, on an accepted miss, set Read_ready=0, mem_req=1 and mem_addr={addr[31:2],2'b00}, latch the index/tag, and enter MISS.
REQ-019 SHALL hold mem_req and mem_addr stable in MISS until an edge with rdy=1 and mem_ready=1.
REQ-020 SHALL, at that edge, write mem_data into the latched line, set its tag, set its valid bit, drive Inst=mem_data and Read_ready=1, drop mem_req, and return to IDLE.
REQ-021 SHALL ignore rn while in MISS; a request pending in the fill cycle is accepted at the next edge.
REQ-022 SHALL hold Inst and Read_ready stable while in IDLE with no accepted request, so a stalled requester can sample them later.
REQ-023 SHALL, on inv=1 in IDLE, clear all valid bits at the edge; inv has priority over a simultaneous rn, which is then not accepted.
REQ-024 SHALL, on inv=1 in MISS, clear all valid bits and still complete the fill and response, but leave the filled line invalid.
REQ-025 SHALL ignore mem_ready outside MISS.
REQ-026 SHALL freeze all registers, including the counters, on any edge where rdy=0.

Reset
REQ-027 SHALL, while rst=0, force state=IDLE, all valid bits=0, Read_ready=0, Inst=0, mem_req=0, mem_addr=0, hit_cnt=0 and miss_cnt=0, independent of clk.
REQ-028 SHALL abandon an in-flight miss when reset asserts mid-MISS, and SHALL NOT raise Read_ready for it after release.
REQ-029 SHALL leave tag and data arrays uninitialised on reset; only the valid bits are cleared.

Configuration
REQ-030 SHALL, with macro ICACHE_STATS_EN defined, increment hit_cnt on each accepted hit and miss_cnt on each accepted miss, saturating at 32'hFFFFFFFF.
REQ-031 SHALL, without ICACHE_STATS_EN, tie hit_cnt and miss_cnt to 0 and synthesise no counter logic.

Verification
REQ-032 SHALL cover a cold miss: after reset, rn=1 with addr=0x00000010 -> mem_req=1, mem_addr=0x00000010; mem_ready with mem_data=0x00500093 -> next cycle Inst=0x00500093, Read_ready=1, mem_req=0.
REQ-033 SHALL cover a hit: re-request addr=0x00000010 -> Inst=0x00500093 and Read_ready=1 one cycle later, mem_req stays 0.
REQ-034 SHALL cover a conflict miss: addr=0x00000050 (same index, tag 1) -> miss, fill 0xDEADBEEF; then addr=0x00000010 -> miss again.
REQ-035 SHALL cover inv during MISS: inv=1 while filling addr=0x20 -> Read_ready=1 with fill data; a re-request of 0x20 misses.
REQ-036 SHALL cover rdy=0 for 3 cycles in MISS with mem_ready pulsing -> no state change; the fill completes on the first rdy=1 and mem_ready=1 edge.
REQ-037 SHALL cover statistics with ICACHE_STATS_EN: 1 miss then 2 hits -> hit_cnt=2, miss_cnt=1; without the macro -> both 0.
